// File: rtl/bsg_test_node_master_multi_if.sv
// bsg_test_node_master_multi_if: channel, trace-ROM and status signals of the replay master
interface bsg_test_node_master_multi_if #(
    parameter int ring_width_p      = 80,
    parameter int num_channels_p    = 2,
    parameter int rom_addr_width_p  = 32,
    parameter int err_count_width_p = 8
);
    localparam int chan_width_lp  = (num_channels_p > 1) ? $clog2(num_channels_p) : 1;
    localparam int trace_width_lp = 4 + chan_width_lp + ring_width_p;
    logic                                     en_i;
    logic [num_channels_p-1:0]                v_i;
    logic [num_channels_p*ring_width_p-1:0]   data_i;
    logic [num_channels_p-1:0]                ready_o;
    logic [num_channels_p-1:0]                v_o;
    logic [num_channels_p*ring_width_p-1:0]   data_o;
    logic [num_channels_p-1:0]                yumi_i;
    logic [rom_addr_width_p-1:0]              rom_addr_o;
    logic [trace_width_lp-1:0]                rom_data_i;
    logic                                     done_o;
    logic                                     error_o;
    logic [err_count_width_p-1:0]             error_count_o;
    modport master (
        input  en_i, v_i, data_i, yumi_i, rom_data_i,
        output ready_o, v_o, data_o, rom_addr_o, done_o, error_o, error_count_o
    );
    modport slave (
        output en_i, v_i, data_i, yumi_i, rom_data_i,
        input  ready_o, v_o, data_o, rom_addr_o, done_o, error_o, error_count_o
    );
endinterface

// File: rtl/bsg_test_node_master_multi.sv
// bsg_test_node_master_multi: trace-replay master driving and checking several ring channels
module bsg_test_node_master_multi #(
    parameter int ring_width_p      = 80,
    parameter int num_channels_p    = 2,
    parameter int rom_addr_width_p  = 32,
    parameter int wait_width_p      = 16,
    parameter int err_count_width_p = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    bsg_test_node_master_multi_if.master bus
);
    localparam int chan_width_lp  = (num_channels_p > 1) ? $clog2(num_channels_p) : 1;
    localparam int trace_width_lp = 4 + chan_width_lp + ring_width_p;

    typedef enum logic [1:0] {EXEC, WAIT, DONE} state_e;

    state_e                       state_r, state_n;
    logic [rom_addr_width_p-1:0]  pc_r, pc_n, pc_inc;
    logic [ring_width_p-1:0]      mask_r, mask_n;
    logic [wait_width_p-1:0]      cnt_r, cnt_n, wait_n;
    logic [err_count_width_p-1:0] err_cnt_r;
    logic                         err_r, err_hit;
    logic [3:0]                   op;
    logic [chan_width_lp-1:0]     chan;
    logic [ring_width_p-1:0]      payload, rx_data;
    logic                         chan_ok, bad, live, send, recv, yumi_sel, v_sel;

    assign op      = bus.rom_data_i[trace_width_lp-1 -: 4];
    assign chan    = bus.rom_data_i[ring_width_p +: chan_width_lp];
    assign payload = bus.rom_data_i[ring_width_p-1:0];
    assign wait_n  = payload[wait_width_p-1:0];
    assign pc_inc  = pc_r + rom_addr_width_p'(1);
    assign chan_ok = 32'(chan) < num_channels_p;
    assign bad     = op > 4'd5 || ((op == 4'd1 || op == 4'd2) && !chan_ok);
    // Reset is folded in so the outputs drop the instant reset asserts, even if word 0 is a SEND
    assign live    = bus.en_i && !reset_i && state_r == EXEC;
    assign send    = live && op == 4'd1 && chan_ok;
    assign recv    = live && op == 4'd2 && chan_ok;

    assign bus.rom_addr_o    = pc_r;
    assign bus.done_o        = state_r == DONE;
    assign bus.error_o       = err_r;
    assign bus.error_count_o = err_cnt_r;

    // Route the active SEND/RECV onto its channel and select that channel's handshake inputs
    always_comb begin
        bus.v_o     = '0;
        bus.ready_o = '0;
        bus.data_o  = '0;
        yumi_sel    = 1'b0;
        v_sel       = 1'b0;
        rx_data     = '0;
        for (int k = 0; k < num_channels_p; k++) begin
            if (chan == chan_width_lp'(k)) begin
                bus.v_o[k]                                = send;
                bus.ready_o[k]                            = recv;
                bus.data_o[k*ring_width_p +: ring_width_p] = send ? payload : '0;
                yumi_sel                                  = bus.yumi_i[k];
                v_sel                                     = bus.v_i[k];
                rx_data                                   = bus.data_i[k*ring_width_p +: ring_width_p];
            end
        end
    end

    // Execute the current trace word: next pc, state, wait count, mask and error event
    always_comb begin
        state_n = state_r;
        pc_n    = pc_r;
        cnt_n   = cnt_r;
        mask_n  = mask_r;
        err_hit = 1'b0;
        if (state_r == WAIT) begin
            cnt_n = cnt_r - wait_width_p'(1);
            if (cnt_r == wait_width_p'(1)) begin
                pc_n    = pc_inc;
                state_n = EXEC;
            end
        end else if (state_r == EXEC) begin
            if (bad) begin
                err_hit = 1'b1;
                pc_n    = pc_inc;
            end else begin
                case (op)
                    4'd1: pc_n = yumi_sel ? pc_inc : pc_r;
                    4'd2: begin
                        pc_n    = v_sel ? pc_inc : pc_r;
                        err_hit = v_sel && ((rx_data ^ payload) & mask_r) != '0;
                    end
                    4'd3: begin
                        pc_n    = (wait_n == '0) ? pc_inc : pc_r;
                        cnt_n   = wait_n;
                        state_n = (wait_n == '0) ? EXEC : WAIT;
                    end
                    4'd4: begin
                        mask_n = payload;
                        pc_n   = pc_inc;
                    end
                    4'd5: state_n = DONE;
                    default: pc_n = pc_inc;
                endcase
            end
        end
    end

    // State register; cycles with en_i low change nothing
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r   <= EXEC;
            pc_r      <= '0;
            cnt_r     <= '0;
            mask_r    <= '1;
            err_r     <= 1'b0;
            err_cnt_r <= '0;
        end else if (bus.en_i) begin
            state_r <= state_n;
            pc_r    <= pc_n;
            cnt_r   <= cnt_n;
            mask_r  <= mask_n;
            err_r   <= err_r | err_hit;
            if (err_hit && err_cnt_r != '1)
                err_cnt_r <= err_cnt_r + err_count_width_p'(1);
        end
    end
endmodule

// File: doc/bsg_test_node_master_multi.md
Name: bsg_test_node_master_multi

Overview:
- Multi-channel trace-replay master for FSB-style ring test benches and on-chip self-test.
- Fetches instructions from an external combinational trace ROM and drives/checks num_channels_p independent ring channels.
- Adds cycle-delay waits, masked receive compare and an error counter, beyond single-channel send/receive replay.
- Sits between the trace ROM and one or more FSB node ports.

Parameters:
- ring_width_p, 80, payload width per channel.
- num_channels_p, 2, number of ring channels (>=1).
- rom_addr_width_p, 32, trace ROM address width.
- wait_width_p, 16, width of WAIT cycle count (<= ring_width_p).
- err_count_width_p, 8, error counter width.
- Derived: chan_width_lp = max(1, clog2(num_channels_p)).
- Derived: trace_width_lp = 4 + chan_width_lp + ring_width_p.
- Trace word layout: [op(4) | chan(chan_width_lp) | payload(ring_width_p)], op in the MSBs.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- en_i  in  1  enable; low freezes all state and deasserts every v_o/ready_o.
- v_i  in  num_channels_p  per-channel input valid.
- data_i  in  num_channels_p*ring_width_p  per-channel input data; channel k in slice k.
- ready_o  out  num_channels_p  per-channel input ready.
- v_o  out  num_channels_p  per-channel output valid.
- data_o  out  num_channels_p*ring_width_p  per-channel output data.
- yumi_i  in  num_channels_p  per-channel consume; late, may depend on v_o.
- rom_addr_o  out  rom_addr_width_p  trace program counter.
- rom_data_i  in  trace_width_lp  trace word, combinational from rom_addr_o.
- done_o  out  1  FINISH reached.
- error_o  out  1  sticky error flag.
- error_count_o  out  err_count_width_p  saturating error count.

Behaviour:
- Reset (async) values: pc=0, state=EXEC, mask=all ones, wait counter=0, done_o=0, error_o=0, error_count_o=0; all v_o/ready_o=0; data_o=0.
- data_o slice = payload only for the selected channel during SEND, else 0.
- States: EXEC, WAIT, DONE. "Cycle" below means an enabled cycle (en_i=1); disabled cycles change nothing.
- Opcodes are decoded in EXEC:
- 0 NOP: pc++ same cycle.
- 1 SEND: v_o[chan]=1, data_o[chan]=payload; pc++ in the cycle yumi_i[chan]=1; otherwise hold. Other channels v_o=0.
- 2 RECV: ready_o[chan]=1; in the cycle v_i[chan]=1: compare (data_i[chan]&mask) with (payload&mask), then pc++. On mismatch set error_o and increment error_count.
- 3 WAIT: n = payload[wait_width_p-1:0].
  - n=0: behaves as NOP.
  - n>0: load cnt=n, go to WAIT. In WAIT, decrement each cycle; when cnt==1, pc++ and return to EXEC.
  - Total occupancy is n+1 cycles; the next op is dispatched n+1 cycles after the WAIT dispatch.
- 4 MASK: mask <= payload; pc++. Applies to all subsequent RECVs.
- 5 FINISH: done_o=1 from the next cycle; enter DONE. pc holds. Only reset leaves DONE.
- 6–15 illegal, or chan >= num_channels_p for SEND/RECV: set error_o, count an error, pc++, no channel activity.
- error_count saturates at all ones.
- error_o never clears except by reset.
- pc wraps mod 2^rom_addr_width_p.
- At most one channel is active per cycle.
- en_i dropping mid-SEND deasserts v_o; yumi_i is ignored while v_o=0. The same op resumes when en_i rises.
- en_i dropping in WAIT freezes cnt.
- Reset mid-operation aborts immediately to reset values. No partial transfer is retained.

Test Plan:
- Program [SEND ch1 0xA5, FINISH]: hold yumi_i[1]=0 for 3 cycles, then pulse. -> v_o[1]=1 for 4 cycles with data 0xA5, v_o[0]=0 throughout; done_o=1 two cycles after the yumi cycle; pc stays at 1.
- Program [RECV ch0 0x1234, FINISH]: drive 0x1234 -> error_o=0. Repeat with 0x1235 -> error_o=1, error_count_o=1.
- Program [MASK 0xFF00, RECV ch0 0x12AA]: drive 0x1255 -> no error (low byte masked).
- Program [WAIT 5, SEND ch0 1]: v_o[0] first asserts exactly 6 cycles after the WAIT dispatch. Repeat with en_i low for 2 cycles mid-wait -> delay becomes 8.
- Program with 300 illegal ops (err_count_width_p=8): error_count_o saturates at 255; error_o=1; pc advances by one per cycle.
- Assert reset_i asynchronously mid-SEND -> v_o, done_o, error_o and pc go to 0 without waiting for a clock edge.
